freq_meter_ctrl: RTL and testbench
==================================

Name: freq_meter_ctrl

Overview:
- Gate-time controller and pulse counter for the frequency-measurement lab.
- Runs from the 50 MHz board clock and generates a gate window of exactly GATE_CYCLES clocks (1 s by default).
- Synchronises an external signal, counts its rising edges while the gate is open, then latches the count as a frequency result with a valid strobe.
- Supports single-shot or continuous back-to-back measurement.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in clk_50MHz cycles; legal range ≥ 2.
- CNT_WIDTH, 26, width of the edge counter and freq_out.
- TIMER_WIDTH, 26, gate timer width; must hold GATE_CYCLES-1.

Ports:
- clk_50MHz  input  1  system clock.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  single-shot request; sampled only in IDLE.
- continuous  input  1  when 1, a new measurement starts automatically; sampled in IDLE and LATCH.
- sig_in  input  1  asynchronous signal under measurement.
- busy  output  1  high in ARM, GATE and LATCH.
- gate  output  1  high in GATE only; edges are counted only while gate is high.
- freq_out  output  CNT_WIDTH  latched edge count of the last completed window.
- freq_valid  output  1  one-cycle strobe; freq_out is new this cycle.
- overflow  output  1  latched with freq_out; 1 if the counter saturated in that window.

Behaviour:
- Reset:
  - Asynchronous on clr_n=0: state=IDLE; busy, gate, freq_valid, overflow = 0; freq_out = 0.
  - Synchroniser, edge counter and timer are cleared.
  - Reset mid-measurement aborts it; no freq_valid is produced.
- Input conditioning:
  - sig_in passes through a 2-flop synchroniser, then a third flop for edge detection.
  - edge = sync & ~prev. These flops run in every state.
  - Pin-to-edge latency is 2-3 clocks.
  - Minimum countable high/low width is 1 clock, so the maximum countable rate is 25 MHz.
- FSM states: IDLE, ARM, GATE, LATCH.
- IDLE:
  - If start=1 or continuous=1, go to ARM. Otherwise stay.
- ARM (1 cycle):
  - Clear the edge counter and the sticky overflow bit.
  - Load timer with GATE_CYCLES-1.
  - Go to GATE.
- GATE:
  - gate=1.
  - If edge=1: counter+1, saturating at all-ones. Setting a saturated counter again sets the sticky overflow bit; reaching all-ones exactly does not.
  - If timer≠0, decrement it. If timer==0, go to LATCH; an edge in that final cycle is still counted.
  - gate is therefore high for exactly GATE_CYCLES consecutive cycles.
- LATCH (1 cycle):
  - On this edge, freq_out ← counter, overflow ← sticky bit, freq_valid ← 1. These are visible in the cycle after LATCH.
  - If continuous=1, go to ARM; otherwise go to IDLE.
- freq_valid is high for exactly one cycle per completed window.
- freq_out and overflow hold their values until the next LATCH or reset.
- Timing:
  - start sampled high in IDLE at edge k → ARM in cycle k+1, gate high in cycles k+2 … k+1+GATE_CYCLES, LATCH in cycle k+2+GATE_CYCLES, freq_valid in the following cycle.
  - In continuous mode, freq_valid strobes are GATE_CYCLES+2 cycles apart, with a 2-cycle dead time (LATCH + ARM) between gates.
- Boundary cases:
  - start while busy is ignored; it is not queued.
  - start and continuous both high in IDLE: a single ARM entry.
  - continuous deasserted during GATE: the current window completes and the FSM then returns to IDLE.
  - Edges during ARM, LATCH or IDLE are not counted.
  - No arithmetic wrap-around in the counter (it saturates); the timer never underflows.

Test Plan:
- GATE_CYCLES=100, sig_in period 10 clocks, single start pulse → gate high exactly 100 cycles; one freq_valid; freq_out=10; overflow=0; busy returns low; no second strobe.
- GATE_CYCLES=100, continuous=1, sig_in period 4 → freq_valid every 102 cycles; every freq_out=25; deassert continuous mid-gate → exactly one further strobe, then IDLE.
- CNT_WIDTH=4, GATE_CYCLES=100, sig_in period 4 → freq_out=15, overflow=1. Next window with sig_in period 10 → freq_out=10, overflow=0 (sticky bit cleared in ARM).
- sig_in held constant high, and separately constant low → freq_out=0. Single 1-cycle high pulse inside the gate → freq_out=1.
- Pulse start repeatedly during GATE → no restart; window length still 100; one freq_valid.
- clr_n low for 3 cycles mid-GATE → all outputs 0 immediately (asynchronously); no freq_valid; subsequent start gives a correct measurement.

Source files
------------

// File: rtl/freq_meter_ctrl.sv
// Gate-time controller and pulse counter.
// Opens a gate of exactly GATE_CYCLES clocks, counts synchronised rising
// edges of sig_in while it is open, then latches the count with a one-cycle
// valid strobe. Single-shot or continuous back-to-back measurement.
module freq_meter_ctrl #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_WIDTH   = 26,
  parameter int unsigned TIMER_WIDTH = 26
) (
  input  logic                 clk_50MHz,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 sig_in,
  output logic                 busy,
  output logic                 gate,
  output logic [CNT_WIDTH-1:0] freq_out,
  output logic                 freq_valid,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_GATE  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(GATE_CYCLES - 1);

  state_t                 state_q;
  logic                   sync1_q, sync2_q, prev_q;
  logic                   sig_edge;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   ovf_sticky_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic                   busy_q, gate_q, valid_q, ovf_q;
  logic [CNT_WIDTH-1:0]   freq_q;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sig_edge = sync2_q & ~prev_q;

  // Measurement FSM; busy/gate are registered from the next state so they
  // are high exactly while the FSM sits in the corresponding states.
  always_ff @(posedge clk_50MHz or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      gate_q       <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      freq_q       <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start || continuous) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          cnt_q        <= '0;
          ovf_sticky_q <= 1'b0;
          timer_q      <= TIMER_LOAD;
          state_q      <= S_GATE;
          gate_q       <= 1'b1;
        end
        S_GATE: begin
          if (sig_edge) begin
            if (cnt_q == '1) ovf_sticky_q <= 1'b1;
            else             cnt_q        <= cnt_q + 1'b1;
          end
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            state_q <= S_LATCH;
            gate_q  <= 1'b0;
          end
        end
        S_LATCH: begin
          freq_q  <= cnt_q;
          ovf_q   <= ovf_sticky_q;
          valid_q <= 1'b1;
          if (continuous) begin
            state_q <= S_ARM;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign gate       = gate_q;
  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl: a 16-bit-counter instance and a
// 4-bit-counter instance share all inputs; both use a 100-cycle gate.
module tb_freq_meter_ctrl;

  localparam int unsigned GC = 100;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic        continuous;
  logic        sig_in;
  logic        busy, gate, freq_valid, overflow;
  logic [15:0] freq_out;
  logic        busy4, gate4, freq_valid4, overflow4;
  logic [3:0]  freq_out4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int period = 0;
  int level = 0;
  int phase = 0;
  int pulse_cyc = -1;

  freq_meter_ctrl #(.GATE_CYCLES(GC), .CNT_WIDTH(16), .TIMER_WIDTH(8)) dut (
    .clk_50MHz(clk), .clr_n(clr_n), .start(start), .continuous(continuous),
    .sig_in(sig_in), .busy(busy), .gate(gate), .freq_out(freq_out),
    .freq_valid(freq_valid), .overflow(overflow)
  );

  freq_meter_ctrl #(.GATE_CYCLES(GC), .CNT_WIDTH(4), .TIMER_WIDTH(8)) dut4 (
    .clk_50MHz(clk), .clr_n(clr_n), .start(start), .continuous(continuous),
    .sig_in(sig_in), .busy(busy4), .gate(gate4), .freq_out(freq_out4),
    .freq_valid(freq_valid4), .overflow(overflow4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus source: constant level, square wave of 'period', or one-cycle pulse.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc == pulse_cyc) sig_in = 1'b1;
      else if (period == 0) sig_in = (level != 0);
      else begin
        phase  = (phase + 1 >= period) ? 0 : phase + 1;
        sig_in = (phase < period / 2);
      end
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One single-shot measurement, sampled at negedges; i counts cycles after
  // the edge that sampled start.
  task automatic run_single(input string tag, input int exp_f, input int exp_o,
                            input int exp_f4, input int exp_o4,
                            input int pulse_off, input bit poke);
    int gcnt = 0, first_gate = -1, vcnt = 0, v4cnt = 0, vat = -1;
    int f = -1, o = -1, f4 = -1, o4 = -1;
    @(negedge clk);
    start = 1'b1;
    if (pulse_off >= 0) pulse_cyc = cyc + pulse_off;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      start = poke && (i >= 5) && (i <= 95) && (i % 6 == 0);
      if (gate) begin
        gcnt++;
        if (first_gate < 0) first_gate = i;
      end
      if (freq_valid) begin
        vcnt++; vat = i; f = int'(freq_out); o = int'(overflow);
      end
      if (freq_valid4) begin
        v4cnt++; f4 = int'(freq_out4); o4 = int'(overflow4);
      end
    end
    start = 1'b0;
    check_eq({tag, ".first_gate"}, first_gate, 2);
    check_eq({tag, ".gate_len"}, gcnt, GC);
    check_eq({tag, ".valid_cnt"}, vcnt, 1);
    check_eq({tag, ".valid_at"}, vat, GC + 3);
    check_eq({tag, ".freq"}, f, exp_f);
    check_eq({tag, ".ovf"}, o, exp_o);
    check_eq({tag, ".valid4_cnt"}, v4cnt, 1);
    check_eq({tag, ".freq4"}, f4, exp_f4);
    check_eq({tag, ".ovf4"}, o4, exp_o4);
    check_eq({tag, ".busy_end"}, int'(busy), 0);
  endtask

  task automatic run_continuous();
    int n = 0, drop_at = -1;
    int pos[8];
    @(negedge clk);
    continuous = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (i == drop_at) continuous = 1'b0;
      if (freq_valid) begin
        if (n < 8) pos[n] = i;
        n++;
        check_eq("cont.freq", int'(freq_out), 25);
        if (n == 3) drop_at = i + 50;
      end
    end
    continuous = 1'b0;
    check_eq("cont.strobes", n, 4);
    check_eq("cont.first", pos[0], GC + 3);
    for (int k = 1; k < 4; k++) check_eq("cont.interval", pos[k] - pos[k-1], GC + 2);
    check_eq("cont.busy_end", int'(busy), 0);
  endtask

  initial begin
    int vcnt;
    clr_n = 1'b0; start = 1'b0; continuous = 1'b0;
    period = 10;
    idle(3);
    check_eq("rst.busy", int'(busy), 0);
    check_eq("rst.gate", int'(gate), 0);
    check_eq("rst.valid", int'(freq_valid), 0);
    check_eq("rst.ovf", int'(overflow), 0);
    check_eq("rst.freq", int'(freq_out), 0);
    clr_n = 1'b1;
    idle(20);

    run_single("p10", 10, 0, 10, 0, -1, 1'b0);
    idle(5);
    check_eq("p10.no_second", int'(freq_valid), 0);

    period = 4;
    idle(20);
    run_continuous();
    idle(10);

    run_single("sat", 25, 0, 15, 1, -1, 1'b0);
    period = 10;
    idle(20);
    run_single("unsat", 10, 0, 10, 0, -1, 1'b0);

    period = 0; level = 1;
    idle(10);
    run_single("const_hi", 0, 0, 0, 0, -1, 1'b0);
    level = 0;
    idle(10);
    run_single("const_lo", 0, 0, 0, 0, -1, 1'b0);
    run_single("pulse", 1, 0, 1, 0, 50, 1'b0);

    period = 10;
    idle(20);
    run_single("poke", 10, 0, 10, 0, -1, 1'b1);

    // Reset in the middle of a gate window.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(50);
    check_eq("abort.gate_before", int'(gate), 1);
    #2 clr_n = 1'b0;
    #1;
    check_eq("abort.busy", int'(busy), 0);
    check_eq("abort.gate", int'(gate), 0);
    check_eq("abort.freq", int'(freq_out), 0);
    check_eq("abort.ovf4", int'(overflow4), 0);
    check_eq("abort.valid", int'(freq_valid), 0);
    idle(3);
    clr_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (freq_valid) vcnt++;
    end
    check_eq("abort.no_valid", vcnt, 0);
    check_eq("abort.idle", int'(busy), 0);
    run_single("after_rst", 10, 0, 10, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
